// File: rtl/pool_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the max-pooling window feeder.
// Holds default sizes, the FSM encoding and a helper that slices one sample out of a flattened window.
package pool_pkg;

   localparam int POOL_DW      = 22;
   localparam int POOL_WIN     = 16;
   localparam int POOL_SETTLE  = 3;
   localparam int POOL_TIMEOUT = 64;

   typedef enum logic [1:0] {
      FILL      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      OUT       = 2'd3
   } pool_state_e;

   // Sample k sits at bits [k*DW +: DW]; slot 0 is the first sample received.
   function automatic logic signed [POOL_DW-1:0] winSample(
      input logic [POOL_WIN*POOL_DW-1:0] flat,
      input int                          k
   );
      return flat[k*POOL_DW +: POOL_DW];
   endfunction

endpackage

// File: rtl/pool_window_feeder.sv
`timescale 1ns/1ps
// Collects WIN streamed samples into a window, presents it to the max-pooling core,
// then forwards the pooled result (or a timeout error) over a downstream valid/ready handshake.
module pool_window_feeder
   import pool_pkg::*;
#(
   parameter int DW      = POOL_DW,
   parameter int WIN     = POOL_WIN,
   parameter int SETTLE  = POOL_SETTLE,
   parameter int TIMEOUT = POOL_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DW-1:0]     s_data,
   output logic [WIN*DW-1:0] win_flat,
   output logic              pool_enable,
   input  logic              pool_done,
   input  logic [DW-1:0]     pool_result,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DW-1:0]     m_data,
   output logic              m_err,
   output logic [15:0]       win_count
);

   localparam int FW = (WIN > 1) ? $clog2(WIN) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [FW-1:0] LAST_SLOT   = FW'(WIN - 1);
   localparam logic [TW-1:0] SETTLE_CNT  = TW'(SETTLE - 1);
   localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT - 1);

   pool_state_e   state_q, state_d;
   logic [FW-1:0] fill_cnt_q, fill_cnt_d;
   logic [TW-1:0] wait_cnt_q, wait_cnt_d;
   logic [DW-1:0] m_data_q, m_data_d;
   logic          m_err_q, m_err_d;
   logic [15:0]   win_count_q, win_count_d;
   logic [DW-1:0] win_q [WIN];
   logic          sample_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         fill_cnt_q  <= '0;
         wait_cnt_q  <= '0;
         m_data_q    <= '0;
         m_err_q     <= 1'b0;
         win_count_q <= '0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         m_data_q    <= m_data_d;
         m_err_q     <= m_err_d;
         win_count_q <= win_count_d;
      end
   end

   // Window buffer only changes while filling, so the core sees a frozen window during pooling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < WIN; k++) begin
            win_q[k] <= '0;
         end
      end else if (sample_we) begin
         win_q[fill_cnt_q] <= s_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      m_data_d    = m_data_q;
      m_err_d     = m_err_q;
      win_count_d = win_count_q;
      sample_we   = 1'b0;
      s_ready     = 1'b0;
      pool_enable = 1'b0;
      m_valid     = 1'b0;

      case (state_q)
         FILL: begin
            s_ready = 1'b1;
            if (s_valid) begin
               sample_we = 1'b1;
               if (fill_cnt_q == LAST_SLOT) begin
                  fill_cnt_d = '0;
                  state_d    = ISSUE;
               end else begin
                  fill_cnt_d = fill_cnt_q + 1'b1;
               end
            end
         end

         ISSUE: begin
            pool_enable = 1'b1;
            wait_cnt_d  = '0;
            state_d     = WAIT_DONE;
         end

         // A done that arrives before the core has settled is ignored; capture wins over timeout.
         WAIT_DONE: begin
            pool_enable = 1'b1;
            wait_cnt_d  = wait_cnt_q + 1'b1;
            if (pool_done && (wait_cnt_q >= SETTLE_CNT)) begin
               m_data_d = pool_result;
               m_err_d  = 1'b0;
               state_d  = OUT;
            end else if (wait_cnt_q == TIMEOUT_CNT) begin
               m_data_d = '0;
               m_err_d  = 1'b1;
               state_d  = OUT;
            end
         end

         OUT: begin
            m_valid = 1'b1;
            if (m_ready) begin
               win_count_d = win_count_q + 16'd1;
               state_d     = FILL;
            end
         end

         default: begin
            state_d = FILL;
         end
      endcase
   end

   for (genvar k = 0; k < WIN; k++) begin : g_flat
      assign win_flat[k*DW +: DW] = win_q[k];
   end

   assign m_data    = m_data_q;
   assign m_err     = m_err_q;
   assign win_count = win_count_q;

endmodule

// File: doc/pool_window_feeder.md
Name: pool_window_feeder

Overview:
- Upstream producer for the 16-input max-pooling core.
- Accepts a serial stream of signed 22-bit activations over a valid/ready handshake and assembles WIN samples into a window buffer.
- Presents the window in parallel to the pooling core with an enable, waits for its done indication, captures the pooled result and forwards it downstream over a second valid/ready handshake.
- Sits between the convolution output stream and the pooling core.

Parameters:
- DW, 22, sample and result width (signed two's complement).
- WIN, 16, samples per pooling window.
- SETTLE, 3, minimum cycles pool_enable is held high before pool_result may be captured.
- TIMEOUT, 64, maximum cycles spent in WAIT_DONE before aborting the window.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  feeder can accept a sample.
- s_data  in  DW  input sample.
- win_flat  out  WIN*DW  window to pooling core; sample k at bits [k*DW +: DW], k=0 is first received.
- pool_enable  out  1  enable to pooling core.
- pool_done  in  1  pooling core done flag.
- pool_result  in  DW  pooling core result, signed.
- m_valid  out  1  pooled result valid.
- m_ready  in  1  downstream accepts result.
- m_data  out  DW  pooled result.
- m_err  out  1  qualifies m_data; 1 = window timed out, m_data is 0.
- win_count  out  16  windows emitted since reset; wraps at 65535 -> 0.

Behaviour:
- Reset (async assert, sync release): state FILL, fill counter 0, window buffer 0. All outputs 0 except s_ready = 1.
- FILL:
  - s_ready = 1. A sample is accepted on an edge with s_valid && s_ready and written to slot fill_cnt.
  - On acceptance of slot WIN-1: fill_cnt -> 0, go to ISSUE.
  - pool_enable = 0; win_flat holds the last window.
- ISSUE (one cycle): s_ready = 0, pool_enable = 1, wait counter cleared. Go to WAIT_DONE.
- WAIT_DONE:
  - pool_enable = 1; win_flat held stable; wait counter increments each cycle.
  - When pool_done == 1 and wait_cnt >= SETTLE-1: capture pool_result into m_data, set m_err = 0, go to OUT.
  - pool_done == 1 earlier than SETTLE is ignored.
  - If wait_cnt reaches TIMEOUT-1 without capture: m_data = 0, m_err = 1, go to OUT.
- OUT:
  - pool_enable = 0, m_valid = 1. m_data and m_err stay stable until m_ready.
  - On m_valid && m_ready: m_valid -> 0, win_count += 1, go to FILL.
  - s_ready goes high the cycle after the handshake.
- Latency: last sample accepted at edge N -> pool_enable high from N+1. With pool_done already high, m_valid is high from N+1+SETTLE.
- Back-to-back windows: minimum WIN + SETTLE + 2 cycles per window with m_ready tied high.
- s_valid in states other than FILL: not accepted, since s_ready = 0. The producer holds its data per handshake rules.
- m_ready asserted while m_valid = 0: ignored.
- Reset mid-operation: the partial window is discarded, pool_enable drops immediately, and any pending m_valid is lost.
- No arithmetic on samples. Signedness matters only for the $signed presentation of m_data.

Decomposition:
- Shared package pool_pkg holds:
  - DW and WIN defaults.
  - State encoding enum {FILL, ISSUE, WAIT_DONE, OUT}.
  - Function to slice sample k from a flattened window.
- The pooling core receives the window unpacked from win_flat at instantiation.
- No sub-module is required. The window buffer is an in-module register array; the FSM and counters are in one process.

Test Plan:
- Reset then stream 16 samples 0,1,…,15 with s_valid held high, pooling core model with done one cycle after enable and result 15 -> win_flat slot 0 = 0 and slot 15 = 15; pool_enable high exactly 3+ cycles; m_data = 15, m_err = 0, win_count = 1.
- Samples including negatives (0x3FFFFF = -1, 0x200000 = most negative, 0x1FFFFF = max), model returns 0x1FFFFF -> m_data = 0x1FFFFF; s_ready = 0 from ISSUE until the OUT handshake.
- Pooling model never asserts done -> after 64 cycles in WAIT_DONE: m_valid = 1, m_err = 1, m_data = 0.
- m_ready held low for 10 cycles in OUT -> m_valid and m_data stable, s_ready = 0, no sample accepted; release m_ready -> next window fills from slot 0.
- rst_n asserted after 7 of 16 samples, then 16 fresh samples 100..115 -> window contains only 100..115; win_count restarts at 0 then 1.
- 4 consecutive windows with m_ready = 1 -> win_count = 4; each window period ≥ 21 cycles; slot ordering preserved.
